// File: rtl/seg7_scan_driver.sv
// Multiplexed multi-digit 7-segment driver with double-buffered digit word.
// Latency: segs_o/an_o are registered and show the idx/active word of the previous cycle.
// Backpressure: none; load_i is always accepted, and the last load in a frame wins.
// Build option: define SEG7_SCAN_BRIGHTNESS_EN to add brightness_i PWM dimming of an_o.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic [DIGITS-1:0]     dp_mask_i,
    input  logic                  load_i,
    input  logic                  hex_mode_i,
    input  logic                  blank_lz_i,
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    input  logic [2:0]            brightness_i,
`endif
    output logic [7:0]            segs_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_tick_o
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                pend_vld_q, pend_vld_d;
    logic [7:0]          segs_q, segs_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_tick_q, frame_tick_d;

    logic                slot_end, frame_wrap;
    logic [3:0]          cur_nib;
    logic                cur_dp, cur_blank, nonzero_seen, slot_on;
    logic [DIGITS-1:0]   cur_onehot;

    // a..g pattern for one nibble; values above 9 show a dash unless hex mode
    function automatic logic [6:0] seg_code(input logic [3:0] nib, input logic hex);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'b1111110;
            4'h1: code = 7'b0110000;
            4'h2: code = 7'b1101101;
            4'h3: code = 7'b1111001;
            4'h4: code = 7'b0110011;
            4'h5: code = 7'b1011011;
            4'h6: code = 7'b1011111;
            4'h7: code = 7'b1110000;
            4'h8: code = 7'b1111111;
            4'h9: code = 7'b1111011;
            4'hA: code = 7'b1110111;
            4'hB: code = 7'b0011111;
            4'hC: code = 7'b1001110;
            4'hD: code = 7'b0111101;
            4'hE: code = 7'b1001111;
            default: code = 7'b1000111;
        endcase
        if (!hex && nib > 4'd9) begin
            code = 7'b0000001;
        end
        return code;
    endfunction

    // Select the digit currently scanned and decide whether it is a blanked leading zero
    always_comb begin
        cur_nib      = '0;
        cur_dp       = 1'b0;
        cur_onehot   = '0;
        cur_blank    = 1'b0;
        nonzero_seen = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib       = act_val_q[4*i +: 4];
                cur_dp        = act_dp_q[i];
                cur_onehot[i] = 1'b1;
            end
        end
        // Walk from the most significant digit down; digit 0 is never blanked.
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (act_val_q[4*i +: 4] != 4'd0) begin
                nonzero_seen = 1'b1;
            end
            if (idx_q == IW'(i) && !nonzero_seen) begin
                cur_blank = blank_lz_i;
            end
        end
    end

    // Scan counters, double-buffer handoff and next output values
    always_comb begin
        slot_end   = (cnt_q == CNT_LAST);
        frame_wrap = slot_end && (idx_q == IDX_LAST);

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        if (load_i) begin
            if (frame_wrap) begin
                // Load coinciding with the wrap bypasses the pending stage.
                act_val_d  = value_i;
                act_dp_d   = dp_mask_i;
                pend_vld_d = 1'b0;
            end else begin
                pend_val_d = value_i;
                pend_dp_d  = dp_mask_i;
                pend_vld_d = 1'b1;
            end
        end else if (frame_wrap && pend_vld_q) begin
            act_val_d  = pend_val_q;
            act_dp_d   = pend_dp_q;
            pend_vld_d = 1'b0;
        end

`ifdef SEG7_SCAN_BRIGHTNESS_EN
        slot_on = (32'(cnt_q) < (((32'(brightness_i) + 32'd1) * 32'(REFRESH_DIV)) >> 3));
`else
        slot_on = 1'b1;
`endif
        an_d         = slot_on ? cur_onehot : '0;
        segs_d       = cur_blank ? {7'b0000000, cur_dp} : {seg_code(cur_nib, hex_mode_i), cur_dp};
        frame_tick_d = frame_wrap;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            segs_q       <= '0;
            an_q         <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            segs_q       <= segs_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign segs_o       = segs_q;
    assign an_o         = an_q;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=8).
// Reference tracks elapsed cycles since reset and the displayed/pending words.
// Every cycle segs/an/frame_tick are compared against the reference.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int F  = D * RD;

    localparam logic [6:0] CODES [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic          clk = 1'b0;
    logic          reset_n;
    logic [15:0]   value;
    logic [3:0]    dp_mask;
    logic          load, hex_mode, blank_lz;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    logic [2:0]    brightness;
`endif
    logic [7:0]    segs;
    logic [3:0]    an;
    logic          frame_tick;

    int total = 0;
    int bad   = 0;
    string phase = "reset";

    // reference state
    int          p;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_pv;
    logic [7:0]  e_segs;
    logic [3:0]  e_an;
    logic        e_ft;

    seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
        .clock_i      (clk),
        .reset_n_i    (reset_n),
        .value_i      (value),
        .dp_mask_i    (dp_mask),
        .load_i       (load),
        .hex_mode_i   (hex_mode),
        .blank_lz_i   (blank_lz),
`ifdef SEG7_SCAN_BRIGHTNESS_EN
        .brightness_i (brightness),
`endif
        .segs_o       (segs),
        .an_o         (an),
        .frame_tick_o (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_segs(input int dig);
        logic [3:0] nib;
        logic [6:0] ag;
        int msd;
        msd = 0;
        for (int i = 0; i < D; i++) begin
            if (m_act[4*i +: 4] != 4'd0) msd = i;
        end
        nib = m_act[4*dig +: 4];
        if (blank_lz && dig > msd)      ag = 7'b0000000;
        else if (nib <= 4'd9 || hex_mode) ag = CODES[nib];
        else                             ag = 7'b0000001;
        return {ag, m_act_dp[dig]};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s/%s cycle=%0d got=%h exp=%h", phase, tag, p, got, exp);
        end
    endtask

    // One clock: derive expectations from pre-edge reference state, update it, then compare.
    task automatic step();
        int dig;
        bit wrap;
        @(posedge clk);
        if (!reset_n) begin
            e_segs = 8'h00; e_an = 4'h0; e_ft = 1'b0;
            p = 0; m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0; m_pv = 0;
        end else begin
            dig    = (p / RD) % D;
            wrap   = ((p % F) == F - 1);
            e_an   = 4'(1 << dig);
`ifdef SEG7_SCAN_BRIGHTNESS_EN
            if ((p % RD) >= ((int'(brightness) + 1) * RD) / 8) e_an = 4'h0;
`endif
            e_segs = ref_segs(dig);
            e_ft   = wrap;
            if (load) begin
                if (wrap) begin m_act = value; m_act_dp = dp_mask; m_pv = 0; end
                else      begin m_pend = value; m_pend_dp = dp_mask; m_pv = 1; end
            end else if (wrap && m_pv) begin
                m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 0;
            end
            p++;
        end
        #1;
        check("segs", 16'(segs), 16'(e_segs));
        check("an", 16'(an), 16'(e_an));
        check("frame_tick", 16'(frame_tick), 16'(e_ft));
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < F && (p % F) != pos; k++) step();
    endtask

    initial begin
        reset_n = 1'b0; value = '0; dp_mask = '0; load = 1'b0;
        hex_mode = 1'b1; blank_lz = 1'b1;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
        brightness = 3'd7;
`endif
        p = 0;
        step(); step();
        reset_n = 1'b1;

        phase = "idle";
        repeat (40) step();

        phase = "load1234";
        value = 16'h1234; dp_mask = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        repeat (70) step();

        phase = "hexAF";
        value = 16'h00AF; dp_mask = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        repeat (40) step();
        phase = "decAF";
        hex_mode = 1'b0;
        repeat (40) step();
        hex_mode = 1'b1;

        phase = "lastwins";
        run_to(5);
        value = 16'h1111; load = 1'b1; step();
        value = 16'h2222; step();
        load = 1'b0;
        run_to(F - 1);
        value = 16'h3333; load = 1'b1; step();
        load = 1'b0;
        repeat (2 * F + 4) step();

        phase = "midreset";
        run_to(2 * RD + 3);
        value = 16'h9876; dp_mask = 4'b1111; load = 1'b1; step();
        load = 1'b0;
        step();
        reset_n = 1'b0; step();
        reset_n = 1'b1;
        repeat (F + 8) step();

`ifdef SEG7_SCAN_BRIGHTNESS_EN
        phase = "dim1";
        brightness = 3'd1;
        repeat (F) step();
        phase = "dim7";
        brightness = 3'd7;
        repeat (F) step();
`endif

        phase = "random";
        for (int n = 0; n < 800; n++) begin
            load     = ($urandom_range(0, 9) == 0);
            value    = 16'($urandom);
            dp_mask  = 4'($urandom);
            hex_mode = 1'($urandom);
            blank_lz = 1'($urandom);
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
            brightness = 3'($urandom);
`endif
            reset_n  = ($urandom_range(0, 199) != 0);
            step();
        end
        reset_n = 1'b1;
        load = 1'b0;
        repeat (F) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
